rr_scheduler: RTL

RR_SCHEDULER -- requirements
Module: rr_scheduler

---
 rtl/rr_scheduler_pkg.sv | 15 +
 rtl/rr_scheduler_if.sv | 32 +++
 rtl/rr_scheduler_pick.sv | 29 ++
 rtl/rr_scheduler.sv | 106 ++++++++++
 4 files changed

// File: rtl/rr_scheduler_pkg.sv
// rr_scheduler shared definitions
// sizes and FSM encoding for the scheduler slice
package rr_scheduler_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DEST_W    = 2;
  localparam int WEIGHT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rr_scheduler_if.sv
// rr_scheduler FIFO-side bundle
// master = scheduler, slave = FIFO fabric
interface rr_scheduler_if #(
  parameter int N = rr_scheduler_pkg::NUM_PORTS,
  parameter int W = rr_scheduler_pkg::WEIGHT_W
);

  localparam int DW = rr_scheduler_pkg::DEST_W;

  logic                 enable;
  logic [N-1:0]         empty_in;
  logic [N-1:0]         almost_full_out;
  logic [N*DW-1:0]      head_dest;
  logic [N*W-1:0]       weights;
  logic [N-1:0]         pop;
  logic [$clog2(N)-1:0] sel;
  logic [N-1:0]         push;
  logic                 busy;

  modport master (
    input  enable, empty_in, almost_full_out,
    input  head_dest, weights,
    output pop, sel, push, busy
  );

  modport slave (
    output enable, empty_in, almost_full_out,
    output head_dest, weights,
    input  pop, sel, push, busy
  );

endinterface

// File: rtl/rr_scheduler_pick.sv
// rr_priority_pick: rotating-priority first-eligible
// scan from ptr upward, wrapping modulo N
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  // lowest offset from ptr wins, so scan offsets high to low
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDX_W'(int'(ptr) + k);
      if (eligible[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_scheduler.sv
// rr_scheduler: weighted round-robin FIFO mover
// pops one input FIFO per cycle, pushes its dest next cycle
module rr_scheduler #(
  parameter int NUM_PORTS = rr_scheduler_pkg::NUM_PORTS,
  parameter int WEIGHT_W  = rr_scheduler_pkg::WEIGHT_W
) (
  input logic           clk,
  input logic           reset,
  rr_scheduler_if.master bus
);

  import rr_scheduler_pkg::*;

  localparam int IDX_W = $clog2(NUM_PORTS);

  state_t               state_q, state_n;
  logic [IDX_W-1:0]     ptr_q, ptr_n;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic [WEIGHT_W-1:0]  cnt_q, cnt_n;
  logic [WEIGHT_W-1:0]  w_g, run;
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] push_q, push_n;
  logic [DEST_W-1:0]    dst;

  // eligible: active, data present, destination has room
  always_comb begin
    elig = '0;
    dst  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      dst     = bus.head_dest[i*DEST_W +: DEST_W];
      elig[i] = bus.enable
              & ~bus.empty_in[i]
              & ~bus.almost_full_out[dst];
    end
  end

  rr_priority_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible (elig),
    .ptr      (ptr_q),
    .grant    (gnt_idx),
    .valid    (gnt_vld)
  );

  // burst accounting; a grant away from ptr opens a new burst
  always_comb begin
    ptr_n  = ptr_q;
    cnt_n  = cnt_q;
    push_n = '0;
    w_g    = bus.weights[gnt_idx*WEIGHT_W +: WEIGHT_W];
    if (w_g == '0) w_g = WEIGHT_W'(1);
    run = (gnt_idx == ptr_q) ? cnt_q + WEIGHT_W'(1)
                             : WEIGHT_W'(1);
    if (gnt_vld) begin
      push_n[bus.head_dest[gnt_idx*DEST_W +: DEST_W]] = 1'b1;
      if (run >= w_g) begin
        ptr_n = gnt_idx + 1'b1;
        cnt_n = '0;
      end else begin
        ptr_n = gnt_idx;
        cnt_n = run;
      end
    end
  end

  // FSM next state
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:  if (gnt_vld) state_n = GRANT;
      GRANT: begin
        if (gnt_vld)          state_n = GRANT;
        else if (!bus.enable) state_n = DRAIN;
        else                  state_n = IDLE;
      end
      DRAIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state, pointer, burst count and registered push
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      push_q  <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      push_q  <= push_n;
    end
  end

  assign bus.pop  = (gnt_vld & ~reset)
                  ? (NUM_PORTS'(1) << gnt_idx) : '0;
  assign bus.sel  = (gnt_vld & ~reset) ? gnt_idx : '0;
  assign bus.push = reset ? '0 : push_q;
  assign bus.busy = ~reset
                  & ((state_q != IDLE) | (|push_q));

endmodule
